wb_write_port: RTL

WB_WRITE_PORT -- requirements
Module: wb_write_port

---
 rtl/wb_write_port_if.sv | 31 +++
 rtl/wb_write_port.sv | 107 ++++++++++
 2 files changed

// File: rtl/wb_write_port_if.sv
// Write-back port bundle: two result sources (ALU, memory) with valid/ready
// handshakes, plus the register-file write channel driven by the port.
interface wb_write_port_if;
    logic        alu_valid;
    logic [3:0]  alu_dest;
    logic [31:0] alu_value;
    logic        alu_ready;
    logic        mem_valid;
    logic [3:0]  mem_dest;
    logic [31:0] mem_value;
    logic        mem_ready;
    logic        WB_WB_EN;
    logic [3:0]  WB_Dest;
    logic [31:0] WB_Value;

    // Surrounding pipeline: offers results, watches ready and the write channel.
    modport master (
        output alu_valid, alu_dest, alu_value,
        output mem_valid, mem_dest, mem_value,
        input  alu_ready, mem_ready,
        input  WB_WB_EN, WB_Dest, WB_Value
    );

    // Write port: accepts results and drives the register-file write.
    modport slave (
        input  alu_valid, alu_dest, alu_value,
        input  mem_valid, mem_dest, mem_value,
        output alu_ready, mem_ready,
        output WB_WB_EN, WB_Dest, WB_Value
    );
endinterface

// File: rtl/wb_write_port.sv
// Write-back port: a small circular FIFO merging ALU and memory results into a
// single register-file write per cycle. Memory has fixed priority; results
// aimed at index 15 are accepted but dropped and flagged in a sticky error.
module wb_write_port #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    wb_write_port_if.slave   bus,
    output logic [14:0]      pending_mask,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             drop_err
);
    localparam int PTR_W = CNT_W - 1;

    logic [3:0]       dest_q  [DEPTH];
    logic [31:0]      value_q [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;
    logic             drop_q;

    logic             mem_fire;
    logic             alu_fire;
    logic             acc_fire;
    logic [3:0]       acc_dest;
    logic [31:0]      acc_value;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] offs [DEPTH];

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign drop_err = drop_q;

    // Ready comes from registered occupancy only; a pending pop does not
    // open a slot in the same cycle.
    assign bus.mem_ready = !full;
    assign bus.alu_ready = !full && !bus.mem_valid;

    assign mem_fire  = bus.mem_valid && bus.mem_ready;
    assign alu_fire  = bus.alu_valid && bus.alu_ready;
    assign acc_fire  = mem_fire || alu_fire;
    assign acc_dest  = mem_fire ? bus.mem_dest  : bus.alu_dest;
    assign acc_value = mem_fire ? bus.mem_value : bus.alu_value;
    assign push      = acc_fire && (acc_dest != 4'd15);
    assign pop       = !empty;

    // Head entry is presented whenever the queue is non-empty; zeros otherwise
    // so stale storage never leaks onto the write channel.
    assign bus.WB_WB_EN = !empty;
    assign bus.WB_Dest  = empty ? '0 : dest_q[head];
    assign bus.WB_Value = empty ? '0 : value_q[head];

    // Pointers, occupancy and the sticky drop flag.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
            drop_q <= 1'b0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            if (acc_fire && (acc_dest == 4'd15)) drop_q <= 1'b1;
        end
    end

    // Entry storage write at the tail.
    // NOTE: the storage array is deliberately not reset; entries are only
    // visible through head/count, which are reset, so stale data is masked.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[tail]  <= acc_dest;
            value_q[tail] <= acc_value;
        end
    end

    // Distance of each slot from the head, used to decide slot validity.
    for (genvar i = 0; i < DEPTH; i++) begin : g_offs
        assign offs[i] = PTR_W'(i) - head;
    end

    // Hazard mask: OR of one-hot dest over the currently valid entries.
    // NOTE: always_comb assigns its output a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < 15; j++) begin
                if (({1'b0, offs[i]} < cnt) && (dest_q[i] == 4'(j)))
                    pending_mask[j] = 1'b1;
            end
        end
    end
endmodule
